axi_i2c_bridge_q: RTL and testbench

AXI_I2C_BRIDGE_Q -- requirements
Module: axi_i2c_bridge_q

---
 rtl/axi_i2c_bridge_q.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_i2c_bridge_q.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_i2c_bridge_q.sv
// AXI-lite style front end for a queued I2C engine. AW/W/AR each land in a
// one-entry holding register, requests are arbitrated round-robin into a
// command FIFO, and a parallel tag FIFO steers in-order engine responses
// back to the B or R channel.
module axi_i2c_bridge_q #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CMD_DEPTH  = 4
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic                  WVALID,
   output logic                  WREADY,
   input  logic [DATA_WIDTH-1:0] WDATA,
   output logic                  BVALID,
   input  logic                  BREADY,
   output logic [1:0]            BRESP,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   output logic                  RVALID,
   input  logic                  RREADY,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic [1:0]            RRESP,
   output logic                  CMD_VALID,
   input  logic                  CMD_READY,
   output logic                  CMD_RW,
   output logic [ADDR_WIDTH-1:0] CMD_ADDR,
   output logic [DATA_WIDTH-1:0] CMD_WDATA,
   input  logic                  RSP_VALID,
   output logic                  RSP_READY,
   input  logic [DATA_WIDTH-1:0] RSP_DATA,
   input  logic                  RSP_ERR
);

   localparam int PW = $clog2(CMD_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(CMD_DEPTH);

   // holding registers
   logic                  aw_held, w_held, ar_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic                  last_grant;   // 0 = write granted last, 1 = read

   logic aw_fire, w_fire, ar_fire;
   logic wr_req, rd_req;
   logic grant_wr, grant_rd, push;

   // command FIFO
   logic                  cmd_rw_mem    [CMD_DEPTH];
   logic [ADDR_WIDTH-1:0] cmd_addr_mem  [CMD_DEPTH];
   logic [DATA_WIDTH-1:0] cmd_wdata_mem [CMD_DEPTH];
   logic [PW-1:0]         cmd_wr_ptr, cmd_rd_ptr;
   logic [PW:0]           cmd_cnt;
   logic                  cmd_pop;

   // tag FIFO (1 = read)
   logic                  tag_mem [CMD_DEPTH];
   logic [PW-1:0]         tag_wr_ptr, tag_rd_ptr;
   logic [PW:0]           tag_cnt;
   logic                  tag_full, head_tag;
   logic                  rsp_fire;

   // response channel registers
   logic                  bvalid_q, rvalid_q;
   logic [1:0]            bresp_q, rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   // Ready outputs are forced low while reset is held.
   assign AWREADY = ARESETn & ~aw_held;
   assign WREADY  = ARESETn & ~w_held;
   assign ARREADY = ARESETn & ~ar_held;

   assign aw_fire = AWVALID & AWREADY;
   assign w_fire  = WVALID  & WREADY;
   assign ar_fire = ARVALID & ARREADY;

   assign wr_req   = aw_held & w_held;
   assign rd_req   = ar_held;
   assign tag_full = (tag_cnt == DEPTH_C);

   // Round-robin arbitration between the write and read requests; the tag
   // FIFO occupancy gates both because it never holds fewer entries than
   // the command FIFO.
   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (!tag_full) begin
         if (wr_req && rd_req) begin
            if (last_grant == 1'b0) grant_rd = 1'b1;
            else                    grant_wr = 1'b1;
         end else if (wr_req) begin
            grant_wr = 1'b1;
         end else if (rd_req) begin
            grant_rd = 1'b1;
         end
      end
   end

   assign push = grant_wr | grant_rd;

   // Capture AW/W/AR beats and release them on the edge that enqueues them.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         aw_held    <= 1'b0;
         w_held     <= 1'b0;
         ar_held    <= 1'b0;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         ar_addr_q  <= '0;
         last_grant <= 1'b0;
      end else begin
         if (aw_fire) begin
            aw_held   <= 1'b1;
            aw_addr_q <= AWADDR;
         end else if (grant_wr) begin
            aw_held <= 1'b0;
         end
         if (w_fire) begin
            w_held   <= 1'b1;
            w_data_q <= WDATA;
         end else if (grant_wr) begin
            w_held <= 1'b0;
         end
         if (ar_fire) begin
            ar_held   <= 1'b1;
            ar_addr_q <= ARADDR;
         end else if (grant_rd) begin
            ar_held <= 1'b0;
         end
         if (push) last_grant <= grant_rd;
      end
   end

   // FIFO storage; contents need no reset since occupancy counters guard them.
   always_ff @(posedge ACLK) begin
      if (push) begin
         cmd_rw_mem[cmd_wr_ptr]    <= grant_rd;
         cmd_addr_mem[cmd_wr_ptr]  <= grant_rd ? ar_addr_q : aw_addr_q;
         cmd_wdata_mem[cmd_wr_ptr] <= grant_rd ? '0 : w_data_q;
         tag_mem[tag_wr_ptr]       <= grant_rd;
      end
   end

   assign CMD_VALID = (cmd_cnt != '0);
   assign CMD_RW    = cmd_rw_mem[cmd_rd_ptr];
   assign CMD_ADDR  = cmd_addr_mem[cmd_rd_ptr];
   assign CMD_WDATA = cmd_wdata_mem[cmd_rd_ptr];
   assign cmd_pop   = CMD_VALID & CMD_READY;

   // Command FIFO pointers and occupancy.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         cmd_wr_ptr <= '0;
         cmd_rd_ptr <= '0;
         cmd_cnt    <= '0;
      end else begin
         if (push)    cmd_wr_ptr <= cmd_wr_ptr + PW'(1);
         if (cmd_pop) cmd_rd_ptr <= cmd_rd_ptr + PW'(1);
         case ({push, cmd_pop})
            2'b10:   cmd_cnt <= cmd_cnt + (PW+1)'(1);
            2'b01:   cmd_cnt <= cmd_cnt - (PW+1)'(1);
            default: cmd_cnt <= cmd_cnt;
         endcase
      end
   end

   assign head_tag  = tag_mem[tag_rd_ptr];
   assign RSP_READY = (tag_cnt != '0) && (head_tag ? !rvalid_q : !bvalid_q);
   assign rsp_fire  = RSP_VALID & RSP_READY;

   // Tag FIFO pointers and occupancy.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         tag_wr_ptr <= '0;
         tag_rd_ptr <= '0;
         tag_cnt    <= '0;
      end else begin
         if (push)     tag_wr_ptr <= tag_wr_ptr + PW'(1);
         if (rsp_fire) tag_rd_ptr <= tag_rd_ptr + PW'(1);
         case ({push, rsp_fire})
            2'b10:   tag_cnt <= tag_cnt + (PW+1)'(1);
            2'b01:   tag_cnt <= tag_cnt - (PW+1)'(1);
            default: tag_cnt <= tag_cnt;
         endcase
      end
   end

   // Write responses: hold BVALID and BRESP until the master takes them.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         bvalid_q <= 1'b0;
         bresp_q  <= 2'b00;
      end else if (rsp_fire && !head_tag) begin
         bvalid_q <= 1'b1;
         bresp_q  <= RSP_ERR ? 2'b10 : 2'b00;
      end else if (bvalid_q && BREADY) begin
         bvalid_q <= 1'b0;
      end
   end

   // Read responses: hold RVALID, RDATA and RRESP until the master takes them.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         rvalid_q <= 1'b0;
         rresp_q  <= 2'b00;
         rdata_q  <= '0;
      end else if (rsp_fire && head_tag) begin
         rvalid_q <= 1'b1;
         rresp_q  <= RSP_ERR ? 2'b10 : 2'b00;
         rdata_q  <= RSP_DATA;
      end else if (rvalid_q && RREADY) begin
         rvalid_q <= 1'b0;
      end
   end

   assign BVALID = bvalid_q;
   assign BRESP  = bresp_q;
   assign RVALID = rvalid_q;
   assign RRESP  = rresp_q;
   assign RDATA  = rdata_q;

endmodule

// File: tb/tb_axi_i2c_bridge_q.sv
// Directed bench for axi_i2c_bridge_q with hand-computed expectations.
module tb_axi_i2c_bridge_q;

   logic        ACLK, ARESETn;
   logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RVALID, RREADY;
   logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
   logic [1:0]  BRESP, RRESP;
   logic        CMD_VALID, CMD_READY, CMD_RW;
   logic [31:0] CMD_ADDR, CMD_WDATA;
   logic        RSP_VALID, RSP_READY, RSP_ERR;
   logic [31:0] RSP_DATA;

   int n_cmp = 0;
   int n_err = 0;

   axi_i2c_bridge_q #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_RW(CMD_RW),
      .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
      .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      AWVALID = 0; AWADDR = 0; WVALID = 0; WDATA = 0;
      ARVALID = 0; ARADDR = 0; BREADY = 1; RREADY = 1;
      CMD_READY = 0; RSP_VALID = 0; RSP_DATA = 0; RSP_ERR = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      ARESETn = 0;
      step();
      step();
      ARESETn = 1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      while (!(AWREADY && WREADY) && n < 20) begin
         step();
         n++;
      end
      chk("wr_ready_wait", 64'(n < 20), 64'd1);
      AWVALID = 1; AWADDR = a; WVALID = 1; WDATA = d;
      step();
      AWVALID = 0; WVALID = 0;
   endtask

   task automatic do_read(input logic [31:0] a);
      ARVALID = 1; ARADDR = a;
      step();
      ARVALID = 0;
   endtask

   logic [31:0] waddr [5];

   initial begin
      idle_inputs();
      ARESETn = 0;
      step();
      // reset values while held
      chk("rst_awready", AWREADY, 0);
      chk("rst_wready", WREADY, 0);
      chk("rst_arready", ARREADY, 0);
      chk("rst_cmd_valid", CMD_VALID, 0);
      chk("rst_bvalid", BVALID, 0);
      chk("rst_rvalid", RVALID, 0);
      chk("rst_rsp_ready", RSP_READY, 0);
      chk("rst_rdata", RDATA, 0);
      step();
      ARESETn = 1;
      #1;
      chk("rel_awready", AWREADY, 1);
      chk("rel_wready", WREADY, 1);
      chk("rel_arready", ARREADY, 1);

      // W first, AW two cycles later
      WVALID = 1; WDATA = 32'hA5;
      step();
      WVALID = 0;
      chk("w_only_wready", WREADY, 0);
      chk("w_only_awready", AWREADY, 1);
      chk("w_only_cmd", CMD_VALID, 0);
      step();
      AWVALID = 1; AWADDR = 32'h10;
      step();
      AWVALID = 0;
      chk("aw_w_cmd_n1", CMD_VALID, 0);
      step();
      chk("wr_cmd_valid", CMD_VALID, 1);
      chk("wr_cmd_rw", CMD_RW, 0);
      chk("wr_cmd_addr", CMD_ADDR, 32'h10);
      chk("wr_cmd_wdata", CMD_WDATA, 32'hA5);
      chk("wr_awready_back", AWREADY, 1);
      chk("wr_wready_back", WREADY, 1);
      chk("wr_rsp_ready", RSP_READY, 1);
      CMD_READY = 1;
      step();
      CMD_READY = 0;
      chk("wr_cmd_popped", CMD_VALID, 0);
      BREADY = 0; RSP_VALID = 1; RSP_ERR = 0;
      step();
      RSP_VALID = 0;
      chk("wr_bvalid", BVALID, 1);
      chk("wr_bresp", BRESP, 2'b00);
      chk("wr_rsp_ready_empty", RSP_READY, 0);
      step();
      chk("wr_bvalid_hold", BVALID, 1);
      BREADY = 1;
      step();
      chk("wr_bvalid_clr", BVALID, 0);

      // AW and W together: CMD_VALID two cycles later; NACK response
      AWVALID = 1; AWADDR = 32'h30; WVALID = 1; WDATA = 32'h77;
      step();
      AWVALID = 0; WVALID = 0;
      chk("lat_n1", CMD_VALID, 0);
      step();
      chk("lat_n2", CMD_VALID, 1);
      chk("lat_addr", CMD_ADDR, 32'h30);
      CMD_READY = 1;
      step();
      CMD_READY = 0;
      RSP_VALID = 1; RSP_ERR = 1;
      step();
      RSP_VALID = 0; RSP_ERR = 0;
      chk("nack_bvalid", BVALID, 1);
      chk("nack_bresp", BRESP, 2'b10);
      step();
      chk("nack_bvalid_clr", BVALID, 0);

      // read with NACK
      do_read(32'h20);
      step();
      chk("rd_cmd_valid", CMD_VALID, 1);
      chk("rd_cmd_rw", CMD_RW, 1);
      chk("rd_cmd_addr", CMD_ADDR, 32'h20);
      chk("rd_cmd_wdata", CMD_WDATA, 0);
      CMD_READY = 1;
      step();
      CMD_READY = 0;
      RREADY = 0; RSP_VALID = 1; RSP_DATA = 32'h5A; RSP_ERR = 1;
      step();
      RSP_VALID = 0; RSP_DATA = 0; RSP_ERR = 0;
      chk("rd_rvalid", RVALID, 1);
      chk("rd_rdata", RDATA, 32'h5A);
      chk("rd_rresp", RRESP, 2'b10);
      step();
      chk("rd_rdata_hold", RDATA, 32'h5A);
      RREADY = 1;
      step();
      chk("rd_rvalid_clr", RVALID, 0);

      // first tie out of reset: read wins, write next cycle
      do_reset();
      ARVALID = 1; ARADDR = 32'h40;
      AWVALID = 1; AWADDR = 32'h50; WVALID = 1; WDATA = 32'h11;
      step();
      ARVALID = 0; AWVALID = 0; WVALID = 0;
      chk("tie_held_ar", ARREADY, 0);
      chk("tie_held_aw", AWREADY, 0);
      step();
      chk("tie1_cmd_valid", CMD_VALID, 1);
      chk("tie1_rw", CMD_RW, 1);
      chk("tie1_addr", CMD_ADDR, 32'h40);
      chk("tie1_arready", ARREADY, 1);
      chk("tie1_awready", AWREADY, 0);
      step();
      chk("tie1_wr_next", AWREADY, 1);
      do_read(32'h60);
      step();
      // three commands outstanding; leave a read response pending
      RREADY = 0; RSP_VALID = 1; RSP_DATA = 32'hCC;
      chk("pre_rst_rsp_ready", RSP_READY, 1);
      step();
      RSP_VALID = 0;
      chk("pre_rst_rvalid", RVALID, 1);
      ARESETn = 0;
      #1;
      chk("arst_cmd_valid", CMD_VALID, 0);
      chk("arst_rvalid", RVALID, 0);
      chk("arst_rdata", RDATA, 0);
      chk("arst_awready", AWREADY, 0);
      chk("arst_rsp_ready", RSP_READY, 0);
      step();
      step();
      ARESETn = 1;
      step();
      chk("post_rst_rvalid", RVALID, 0);
      chk("post_rst_bvalid", BVALID, 0);
      chk("post_rst_cmd_valid", CMD_VALID, 0);
      chk("post_rst_arready", ARREADY, 1);
      RREADY = 1;

      // tie after a read grant: write wins
      do_read(32'h60);
      step();
      ARVALID = 1; ARADDR = 32'h70;
      AWVALID = 1; AWADDR = 32'h80; WVALID = 1; WDATA = 32'h22;
      step();
      ARVALID = 0; AWVALID = 0; WVALID = 0;
      step();
      chk("tie2_awready", AWREADY, 1);
      chk("tie2_arready", ARREADY, 0);
      step();
      chk("tie2_rd_next", ARREADY, 1);
      CMD_READY = 1;
      #0;
      chk("order0_addr", CMD_ADDR, 32'h60);
      step();
      chk("order1_addr", CMD_ADDR, 32'h80);
      chk("order1_rw", CMD_RW, 0);
      chk("order1_wdata", CMD_WDATA, 32'h22);
      step();
      chk("order2_addr", CMD_ADDR, 32'h70);
      chk("order2_rw", CMD_RW, 1);
      step();
      CMD_READY = 0;
      chk("order_empty", CMD_VALID, 0);

      // five writes into a four-deep bridge
      do_reset();
      waddr[0] = 32'h100; waddr[1] = 32'h104; waddr[2] = 32'h108;
      waddr[3] = 32'h10C; waddr[4] = 32'h110;
      for (int i = 0; i < 5; i++) do_write(waddr[i], 32'h1000 + i);
      step();
      step();
      chk("full_awready", AWREADY, 0);
      chk("full_wready", WREADY, 0);
      chk("full_head", CMD_ADDR, 32'h100);
      CMD_READY = 1;
      step();
      CMD_READY = 0;
      chk("full_after_cmd_pop", AWREADY, 0);
      RSP_VALID = 1;
      chk("full_rsp_ready", RSP_READY, 1);
      step();
      RSP_VALID = 0;
      chk("pop_edge_no_enq", AWREADY, 0);
      chk("full_bvalid", BVALID, 1);
      step();
      chk("fifth_enq_aw", AWREADY, 1);
      chk("fifth_enq_w", WREADY, 1);
      CMD_READY = 1;
      for (int j = 1; j < 5; j++) begin
         chk($sformatf("wrap_addr%0d", j), CMD_ADDR, waddr[j]);
         chk($sformatf("wrap_data%0d", j), CMD_WDATA, 32'h1000 + j);
         step();
      end
      CMD_READY = 0;
      chk("wrap_empty", CMD_VALID, 0);

      // write then read outstanding with B stalled
      do_reset();
      do_write(32'h90, 32'h33);
      step();
      do_read(32'hA0);
      step();
      BREADY = 0; RSP_VALID = 1; RSP_ERR = 0;
      step();
      RSP_VALID = 0;
      chk("bstall_bvalid", BVALID, 1);
      chk("bstall_rvalid", RVALID, 0);
      chk("bstall_rd_ready", RSP_READY, 1);
      step();
      chk("bstall_rvalid2", RVALID, 0);
      BREADY = 1;
      step();
      chk("brel_bvalid", BVALID, 0);
      RSP_VALID = 1; RSP_DATA = 32'hBB;
      step();
      RSP_VALID = 0;
      chk("brel_rvalid", RVALID, 1);
      chk("brel_rdata", RDATA, 32'hBB);
      chk("brel_rresp", RRESP, 2'b00);
      step();
      chk("brel_rvalid_clr", RVALID, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
